// File: rtl/simd_pkg.sv
// simd_pkg: shared types and helpers for the SIMD accumulator.
//   state_e      - accumulator FSM state (ACCUM, DUMP)
//   simd_word_t  - 48-bit packed SIMD word
//   lane_width() - lane width in bits for a given lane count
package simd_pkg;

   localparam int unsigned SIMD_W = 48;

   typedef logic [SIMD_W-1:0] simd_word_t;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DUMP  = 1'b1
   } state_e;

   // A zero lane count would divide by zero before the legality check can fire.
   function automatic int unsigned lane_width(input int unsigned lanes);
      return (lanes == 0) ? SIMD_W : SIMD_W / lanes;
   endfunction

endpackage

// File: rtl/simd_lane_add.sv
// simd_lane_add: one LW-bit signed adder with overflow detection.
//   a_i, b_i - signed operands
//   sum_o    - LW-bit result (wrapped, or clamped when SIMD_ACCUM_SAT_EN is defined)
//   ovf_o    - signed overflow of a_i + b_i
// Build option: define SIMD_ACCUM_SAT_EN to saturate instead of wrapping.
module simd_lane_add
   import simd_pkg::*;
#(
   parameter int unsigned LW = 12
) (
   input  logic [LW-1:0] a_i,
   input  logic [LW-1:0] b_i,
   output logic [LW-1:0] sum_o,
   output logic          ovf_o
);

   logic [LW-1:0] raw;

   assign raw   = a_i + b_i;
   // Overflow only when both operands share a sign and the result does not.
   assign ovf_o = (a_i[LW-1] == b_i[LW-1]) && (raw[LW-1] != a_i[LW-1]);

`ifdef SIMD_ACCUM_SAT_EN
   always_comb begin
      sum_o = raw;
      if (ovf_o) begin
         sum_o = a_i[LW-1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
      end
   end
`else
   assign sum_o = raw;
`endif

endmodule

// File: rtl/simd_accum.sv
// simd_accum: per-lane accumulation of NACC packed signed samples, then dump.
//   clk_i, rst_i                       - clock, async active-high reset
//   in_data_i/in_valid_i/in_ready_o    - sample input handshake (lane k at [k*LW +: LW])
//   flush_i                            - dump a partial frame early
//   out_data_o/out_ovf_o/out_count_o   - lane sums, sticky overflow flags, sample count
//   out_valid_o/out_ready_i            - frame output handshake
// Build option: SIMD_ACCUM_SAT_EN selects saturating lanes (see simd_lane_add).
module simd_accum
   import simd_pkg::*;
#(
   parameter int unsigned LANES   = 4,
   parameter int unsigned NACC    = 16,
   parameter int unsigned OUT_REG = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [47:0] in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic        flush_i,
   output logic [47:0] out_data_o,
   output logic [3:0]  out_ovf_o,
   output logic [15:0] out_count_o,
   output logic        out_valid_o,
   input  logic        out_ready_i
);

   localparam int unsigned LW     = lane_width(LANES);
   localparam logic [15:0] NACC_W = 16'(NACC);

   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $fatal(1, "simd_accum: LANES must be 1, 2 or 4 (got %0d)", LANES);
   end
   if (NACC == 0 || NACC > 65535) begin : g_bad_nacc
      $fatal(1, "simd_accum: NACC must be in 1..65535 (got %0d)", NACC);
   end

   state_e     state_q, state_d;
   logic       run_q;
   logic [15:0] cnt_q, cnt_d;
   simd_word_t acc_q, acc_d, sum_w;
   logic [3:0] ovf_q, ovf_d, lane_ovf_w;
   logic       in_hs, out_hs;

   for (genvar k = 0; k < 4; k++) begin : g_lane
      if (k < LANES) begin : g_on
         simd_lane_add #(.LW(LW)) u_add (
            .a_i   (acc_q[k*LW +: LW]),
            .b_i   (in_data_i[k*LW +: LW]),
            .sum_o (sum_w[k*LW +: LW]),
            .ovf_o (lane_ovf_w[k])
         );
      end else begin : g_off
         assign lane_ovf_w[k] = 1'b0;
      end
   end

   // run_q holds ready low through reset and rises on the first clock after release.
   assign in_ready_o = run_q && (state_q == ACCUM);
   assign in_hs      = in_valid_i && in_ready_o;
   assign out_hs     = out_valid_o && out_ready_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ACCUM: begin
            if (in_hs) begin
               if (cnt_q == 16'd0) begin
                  acc_d = in_data_i;
                  ovf_d = '0;
                  cnt_d = 16'd1;
               end else begin
                  acc_d = sum_w;
                  ovf_d = ovf_q | lane_ovf_w;
                  cnt_d = cnt_q + 16'd1;
               end
            end
            // cnt_d != 0 covers both a partial frame and a sample arriving with the flush.
            if ((in_hs && cnt_d == NACC_W) || (flush_i && cnt_d != 16'd0)) begin
               state_d = DUMP;
            end
         end
         DUMP: begin
            if (out_hs) begin
               state_d = ACCUM;
               cnt_d   = 16'd0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ACCUM;
         run_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic [47:0] data_q;
      logic [3:0]  ovfo_q;
      logic [15:0] count_q;
      logic        valid_q;

      // Capture once per DUMP; the FSM sits in DUMP until this copy is taken.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            data_q  <= '0;
            ovfo_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
         end else if (state_q == DUMP && !valid_q) begin
            data_q  <= acc_q;
            ovfo_q  <= ovf_q;
            count_q <= cnt_q;
            valid_q <= 1'b1;
         end else if (out_hs) begin
            valid_q <= 1'b0;
         end
      end

      assign out_data_o  = data_q;
      assign out_ovf_o   = ovfo_q;
      assign out_count_o = count_q;
      assign out_valid_o = valid_q;
   end else begin : g_ocomb
      assign out_data_o  = acc_q;
      assign out_ovf_o   = ovf_q;
      assign out_count_o = cnt_q;
      assign out_valid_o = (state_q == DUMP);
   end

endmodule

// File: doc/simd_accum.md
SIMD_ACCUM -- requirements
Module: simd_accum

Interface
REQ-001 Parameter LANES, default 4, SIMD lane count; legal values are 1, 2 and 4; lane width LW = 48/LANES (48, 24 or 12 bits).
REQ-002 Parameter NACC, default 16, samples per accumulation frame; legal range 1..65535.
REQ-003 Parameter OUT_REG, default 1; when 1, out_data_o and out_ovf_o come from a register stage.
REQ-004 clk_i  in  1  single clock; all logic is rising-edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 in_data_i  in  48  packed signed lanes; lane k occupies bits [k*LW +: LW].
REQ-007 in_valid_i  in  1; in_ready_o  out  1; input handshake.
REQ-008 flush_i  in  1  requests an early dump of a partial frame.
REQ-009 out_data_o  out  48  packed lane sums.
REQ-010 out_ovf_o  out  4  sticky per-lane signed-overflow flags; bits at index >= LANES read 0.
REQ-011 out_count_o  out  16  number of samples in the dumped frame.
REQ-012 out_valid_o  out  1; out_ready_i  in  1; output handshake.

Function
REQ-013 The FSM has two states: ACCUM and DUMP; in_ready_o = (state == ACCUM).
REQ-014 In ACCUM, a handshake with cnt == 0 loads acc = sample, clears the ovf flags and sets cnt = 1.
REQ-015 In ACCUM, a handshake with cnt > 0 performs acc = acc + sample per lane and cnt = cnt + 1.
REQ-016 Lane additions are independent: no carry crosses a lane boundary, and each lane result is LW bits.
REQ-017 A lane's ovf bit sets when its operands have equal signs and the result sign differs; it stays set until the next frame load.
REQ-018 The FSM goes to DUMP on the edge where cnt reaches NACC; out_valid_o rises on the next cycle (OUT_REG=0) or one cycle later (OUT_REG=1).
REQ-019 If flush_i is high in ACCUM with cnt > 0, the FSM dumps; a sample handshaking in the same cycle is included in the frame.
REQ-020 If flush_i is high with cnt == 0 and no handshake, the request is ignored; flush_i is ignored entirely in DUMP.
REQ-021 out_valid_o holds, with stable out_* values, until out_ready_i is high.
REQ-022 On the output handshake the FSM returns to ACCUM and cnt = 0; the next sample may be accepted on the following cycle.
REQ-023 When NACC = 1, every accepted sample produces one output frame equal to that sample.

Reset
REQ-024 On rst_i assertion, immediately and regardless of clock: state = ACCUM, cnt = 0, acc = 0, out_data_o = 0, out_ovf_o = 0, out_count_o = 0, out_valid_o = 0.
REQ-025 Reset during a partial frame or pending DUMP discards that frame; no output is produced for it.
REQ-026 in_ready_o is 0 while rst_i is high, and 1 on the first clock after release.

Configuration
REQ-027 Macro SIMD_ACCUM_SAT_EN, when defined: on overflow a lane clamps to +2^(LW-1)-1 or -2^(LW-1), and ovf still sets.
REQ-028 Without SIMD_ACCUM_SAT_EN, lanes wrap modulo 2^LW and only ovf reports the overflow.

Structure
REQ-029 Package simd_pkg holds: the state enum (ACCUM, DUMP), the function lane_width(LANES), and the 48-bit SIMD word typedef.
REQ-030 Sub-module simd_lane_add: one LW-bit signed adder with overflow detect and optional saturation, instantiated LANES times via generate.
REQ-031 Illegal LANES or NACC values stop elaboration with $fatal.

Verification
REQ-032 LANES=4, NACC=4, four samples of 0x001_001_001_001, out_ready_i=1 -> out_data_o = 0x004_004_004_004, out_ovf_o = 0, out_count_o = 4.
REQ-033 LANES=4, NACC=2, samples 0x000_000_000_7FF then 0x000_000_000_001 -> lane0 = 0x800 and ovf = 4'b0001 (wrap); lane0 = 0x7FF with SIMD_ACCUM_SAT_EN.
REQ-034 LANES=2, NACC=8, three samples of 0x000005_000003 with flush_i on the 3rd handshake -> out_data_o = 0x00000F_000009, out_count_o = 3.
REQ-035 NACC=4, out_ready_i held 0 for 10 cycles in DUMP -> out_valid_o and data stay stable and in_ready_o = 0; the frame completes on release.
REQ-036 rst_i pulsed asynchronously mid-frame after 2 of 4 samples -> all outputs 0 at once; the next frame of four 0x001 samples yields exactly 0x004 per lane.
REQ-037 LANES=1, NACC=1, random back-to-back traffic with random out_ready_i -> outputs match the scoreboard 1:1, with no drops or duplicates.
